jtgng_timer_rx: RTL
===================

Name: jtgng_timer_rx

Overview:
- Receiver/decoder for the CAPCOM-style video timing bus (LHBL, LVBL, HS, VS, pixel cen) that the timer block generates.
- Recovers local pixel/line counters aligned to blanking edges.
- Measures line/frame geometry and sync widths, and flags lock once the timing is stable.
- Sits on the consuming side of the timing bus: scaler/scan-doubler front end, OSD overlay, or a bench checker.

Parameters:
- LOCK_FRAMES, 4, consecutive identical frames required before locked asserts.
- CW, 10, width of horizontal counters/measurements. Values saturate at 2^CW-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cen  in  1  pixel clock enable (6 MHz); all sampling and counting happens only when cen=1
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- HS  in  1  horizontal sync, active high
- VS  in  1  vertical sync, active high
- hcnt  out  CW  pixel index within line; 0 = first active pixel
- vcnt  out  9  line index within frame; 0 = first active line
- htotal  out  CW  cens per line (last complete line)
- hactive  out  CW  cens with LHBL=1 per line
- vtotal  out  9  lines per frame (last complete frame)
- vactive  out  9  lines with LVBL=1 per frame
- hs_width  out  8  cens HS high (last pulse)
- vs_width  out  4  lines with VS high (last pulse)
- line_start  out  1  1-clk pulse on the cen where an LHBL rise is detected
- frame_start  out  1  1-clk pulse on line_start where the active frame begins
- locked  out  1  stable-timing flag
- nosig  out  1  no LHBL rise for 2^CW-1 cens

Behaviour:
- Reset: every output is 0, including locked and nosig. All previous-sample registers are 0. Internal valid flags are cleared.
- Edge detection: each input is registered on cen. A rise or fall is current=1/prev=0 or current=0/prev=1, evaluated on the same cen.
- Horizontal index k:
  - k=0 on the LHBL-rise cen; otherwise k = previous k+1, saturating.
  - hcnt shows k one clk later (registered).
- hactive: on an LHBL fall, hactive <= k.
- htotal: on an LHBL rise, htotal <= previous k+1. Latched only once hvalid is set, i.e. after the first rise following reset.
- hs_width:
  - A counter counts cens with HS=1.
  - On the HS fall, hs_width <= count, saturating at 255.
  - The count clears on the HS rise.
- Vertical: all vertical logic steps only on line_start. LVBL and VS are sampled at that same cen.
- Line index j: j=0 when LVBL=1 and LVBL was 0 at the previous line_start (frame_start); otherwise j = previous j+1, saturating at 511. vcnt <= j.
- vactive: at the first line_start with LVBL=0 after active lines, vactive <= j.
- vtotal: at frame_start, vtotal <= previous j+1, once vvalid is set.
- vs_width: counts line_starts with VS=1. It latches at the first line_start with VS=0 after a pulse.
- Simultaneous LHBL and LVBL edges on the same cen are the normal case. The horizontal update happens first, then the vertical update uses the new line.
- Lock logic:
  - At each frame_start, compare the new htotal, hactive, vtotal and vactive against the previous frame's snapshot.
  - On a match, the match counter increments (saturating). On a mismatch, the counter clears and locked drops on that clk.
  - locked=1 when the counter reaches LOCK_FRAMES.
  - Any line within a frame whose htotal differs from the frame's first line marks that frame as a mismatch.
- Timeout: when k saturates, nosig=1, locked=0, the match counter clears, and hvalid/vvalid clear. nosig clears on the next LHBL rise.
- Reset mid-frame: the first partial line and frame after reset are never latched into htotal/vtotal. locked requires LOCK_FRAMES full frames after the first frame_start.
- cen=0 cycles: no state changes. line_start and frame_start stay low.

Test Plan:
- Nominal 6 MHz timing (384 cens/line, LHBL high 256 cens, 262 lines, LVBL high 224 lines, HS high 28 cens, VS 3 lines) -> htotal=384, hactive=256, vtotal=262, vactive=224, hs_width=28, vs_width=3. locked rises at the 5th frame_start after reset.
- Nominal timing, check counters -> hcnt runs 0..383 once per line; vcnt=0 on the first active line and 223 on the last; frame_start pulses once per 262 line_starts.
- Change one frame's line length to 383 while locked -> locked falls at the next frame_start. It re-asserts after 4 further good frames.
- Hold LHBL low for 1100 cens -> nosig=1 and locked=0 at k=1023. nosig clears on the next LHBL rise. htotal is not updated from the broken line.
- Assert rst mid-frame, then release -> all outputs 0. The first htotal is latched only at the second LHBL rise. vtotal first updates at the second frame_start.
- Insert random cen=0 gaps into nominal timing -> all measurements are identical to the gap-free run.

Source files
------------

// File: rtl/jtgng_timer_rx.sv
// Timing-bus receiver: rebuilds pixel/line counters from LHBL/LVBL/HS/VS,
// measures line/frame geometry and sync widths, and reports lock / loss of signal.
module jtgng_timer_rx #(
  parameter int LOCK_FRAMES = 4,
  parameter int CW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic          HS,
  input  logic          VS,
  output logic [CW-1:0] hcnt,
  output logic [8:0]    vcnt,
  output logic [CW-1:0] htotal,
  output logic [CW-1:0] hactive,
  output logic [8:0]    vtotal,
  output logic [8:0]    vactive,
  output logic [7:0]    hs_width,
  output logic [3:0]    vs_width,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked,
  output logic          nosig
);
  localparam logic [CW-1:0] KMAX   = '1;
  localparam int            LW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] LOCK_N = LW'(LOCK_FRAMES);

  logic          lhbl_q, lhbl_d, hs_q, hs_d, lvbl_q, lvbl_d, vs_q, vs_d;
  logic [CW-1:0] k_q, k_d, htotal_q, htotal_d, hactive_q, hactive_d;
  logic [8:0]    j_q, j_d, vtotal_q, vtotal_d, vactive_q, vactive_d;
  logic [7:0]    hs_cnt_q, hs_cnt_d, hs_width_q, hs_width_d;
  logic [3:0]    vs_cnt_q, vs_cnt_d, vs_width_q, vs_width_d;
  logic          hvalid_q, hvalid_d, vvalid_q, vvalid_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic          locked_q, locked_d, nosig_q, nosig_d;
  logic [LW-1:0] match_q, match_d;
  logic          snap_valid_q, snap_valid_d, frame_bad_q, frame_bad_d;
  logic [CW-1:0] snap_ht_q, snap_ht_d, snap_ha_q, snap_ha_d, ref_ht_q, ref_ht_d;
  logic [8:0]    snap_vt_q, snap_vt_d, snap_va_q, snap_va_d;
  logic          lrise, lfall, fs;
  logic [CW-1:0] k_inc;
  logic [8:0]    j_inc;

  always_comb begin
    lhbl_d = lhbl_q;  hs_d = hs_q;  lvbl_d = lvbl_q;  vs_d = vs_q;
    k_d = k_q;  htotal_d = htotal_q;  hactive_d = hactive_q;
    j_d = j_q;  vtotal_d = vtotal_q;  vactive_d = vactive_q;
    hs_cnt_d = hs_cnt_q;  hs_width_d = hs_width_q;
    vs_cnt_d = vs_cnt_q;  vs_width_d = vs_width_q;
    hvalid_d = hvalid_q;  vvalid_d = vvalid_q;
    line_start_d = 1'b0;  frame_start_d = 1'b0;
    nosig_d = nosig_q;  match_d = match_q;
    snap_valid_d = snap_valid_q;  frame_bad_d = frame_bad_q;
    snap_ht_d = snap_ht_q;  snap_ha_d = snap_ha_q;  ref_ht_d = ref_ht_q;
    snap_vt_d = snap_vt_q;  snap_va_d = snap_va_q;
    lrise = 1'b0;  lfall = 1'b0;  fs = 1'b0;
    k_inc = (k_q == KMAX) ? KMAX : k_q + 1'b1;
    j_inc = (j_q == 9'h1FF) ? j_q : j_q + 1'b1;

    if (cen) begin
      lrise = LHBL & ~lhbl_q;
      lfall = ~LHBL & lhbl_q;
      lhbl_d = LHBL;
      hs_d = HS;
      line_start_d = lrise;

      if (lrise) begin
        k_d = '0;
        nosig_d = 1'b0;
        hvalid_d = 1'b1;
        if (hvalid_q) htotal_d = k_inc;
      end else begin
        k_d = k_inc;
        // A line that never ends invalidates every measurement in flight
        if (k_inc == KMAX) begin
          nosig_d = 1'b1;
          match_d = '0;
          hvalid_d = 1'b0;
          vvalid_d = 1'b0;
          snap_valid_d = 1'b0;
        end
      end
      if (lfall) hactive_d = k_d;

      if (HS && !hs_q) hs_cnt_d = 8'd1;
      else if (HS && hs_cnt_q != 8'hFF) hs_cnt_d = hs_cnt_q + 8'd1;
      if (!HS && hs_q) hs_width_d = hs_cnt_q;

      if (lrise) begin
        lvbl_d = LVBL;
        vs_d = VS;
        fs = LVBL & ~lvbl_q;
        frame_start_d = fs;
        j_d = fs ? 9'd0 : j_inc;
        if (!LVBL && lvbl_q) vactive_d = j_d;

        if (VS && !vs_q) vs_cnt_d = 4'd1;
        else if (VS && vs_cnt_q != 4'hF) vs_cnt_d = vs_cnt_q + 4'd1;
        if (!VS && vs_q) vs_width_d = vs_cnt_q;

        if (fs) begin
          if (vvalid_q) begin
            vtotal_d = j_inc;
            if (frame_bad_q || htotal_d != ref_ht_q ||
                (snap_valid_q && {htotal_d, hactive_d, vtotal_d, vactive_d} !=
                                 {snap_ht_q, snap_ha_q, snap_vt_q, snap_va_q}))
              match_d = '0;
            else if (match_q != LOCK_N)
              match_d = match_q + 1'b1;
            snap_ht_d = htotal_d;
            snap_ha_d = hactive_d;
            snap_vt_d = vtotal_d;
            snap_va_d = vactive_d;
            snap_valid_d = 1'b1;
          end
          vvalid_d = 1'b1;
          ref_ht_d = htotal_d;
          frame_bad_d = 1'b0;
        end else if (htotal_d != ref_ht_q) begin
          frame_bad_d = 1'b1;
        end
      end
    end
    locked_d = (match_d == LOCK_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lhbl_q <= 1'b0;  hs_q <= 1'b0;  lvbl_q <= 1'b0;  vs_q <= 1'b0;
      k_q <= '0;  htotal_q <= '0;  hactive_q <= '0;
      j_q <= '0;  vtotal_q <= '0;  vactive_q <= '0;
      hs_cnt_q <= '0;  hs_width_q <= '0;  vs_cnt_q <= '0;  vs_width_q <= '0;
      hvalid_q <= 1'b0;  vvalid_q <= 1'b0;
      line_start_q <= 1'b0;  frame_start_q <= 1'b0;
      locked_q <= 1'b0;  nosig_q <= 1'b0;  match_q <= '0;
      snap_valid_q <= 1'b0;  frame_bad_q <= 1'b0;
      snap_ht_q <= '0;  snap_ha_q <= '0;  ref_ht_q <= '0;
      snap_vt_q <= '0;  snap_va_q <= '0;
    end else begin
      lhbl_q <= lhbl_d;  hs_q <= hs_d;  lvbl_q <= lvbl_d;  vs_q <= vs_d;
      k_q <= k_d;  htotal_q <= htotal_d;  hactive_q <= hactive_d;
      j_q <= j_d;  vtotal_q <= vtotal_d;  vactive_q <= vactive_d;
      hs_cnt_q <= hs_cnt_d;  hs_width_q <= hs_width_d;
      vs_cnt_q <= vs_cnt_d;  vs_width_q <= vs_width_d;
      hvalid_q <= hvalid_d;  vvalid_q <= vvalid_d;
      line_start_q <= line_start_d;  frame_start_q <= frame_start_d;
      locked_q <= locked_d;  nosig_q <= nosig_d;  match_q <= match_d;
      snap_valid_q <= snap_valid_d;  frame_bad_q <= frame_bad_d;
      snap_ht_q <= snap_ht_d;  snap_ha_q <= snap_ha_d;  ref_ht_q <= ref_ht_d;
      snap_vt_q <= snap_vt_d;  snap_va_q <= snap_va_d;
    end
  end

  assign hcnt        = k_q;
  assign vcnt        = j_q;
  assign htotal      = htotal_q;
  assign hactive     = hactive_q;
  assign vtotal      = vtotal_q;
  assign vactive     = vactive_q;
  assign hs_width    = hs_width_q;
  assign vs_width    = vs_width_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign nosig       = nosig_q;
endmodule
